// File: rtl/mul_issue_unit_pkg.sv
// rtl/mul_issue_unit_pkg.sv - shared encodings and parameter bounds for the multiplier issue unit
package mul_issue_unit_pkg;

  localparam int TAG_W_DEFAULT = 5;
  localparam int LATENCY_MIN   = 1;
  localparam int LATENCY_MAX   = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_issue_unit_multiplier.sv
// rtl/mul_issue_unit_multiplier.sv - combinational 32x32 signed multiplier core
module Multiplier (
  input  logic [31:0] multiplier,
  input  logic [31:0] multiplicand,
  output logic [31:0] product
);

  logic signed [63:0] full_product;
  logic               unused_mid_bits;

  // Full signed product; only the sign bit and the low 31 bits leave the core.
  assign full_product    = $signed(multiplier) * $signed(multiplicand);
  assign product         = {full_product[63], full_product[30:0]};
  assign unused_mid_bits = ^full_product[62:31];

endmodule

// File: rtl/mul_issue_unit.sv
// rtl/mul_issue_unit.sv - valid/ready issue and capture wrapper around the multicycle multiplier core
module mul_issue_unit
  import mul_issue_unit_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int TAG_W   = TAG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_latency_check
    $error("mul_issue_unit: LATENCY must lie within 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  logic [TAG_W-1:0] op_tag_q, op_tag_d;
  logic [31:0]      res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      core_result;
  logic             can_accept;
  logic             accept;

  // Core sees only the held operand registers, so its inputs move on accept edges alone.
  Multiplier u_core (
    .multiplier   (op_a_q),
    .multiplicand (op_b_q),
    .product      (core_result)
  );

  // Reset is applied only on the port; while reset is high the flops ignore accept anyway.
  assign can_accept = !flush && (state_q == ST_IDLE || (state_q == ST_DONE && out_ready));
  assign accept     = in_valid && can_accept;
  assign in_ready   = !reset && can_accept;
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign out_result = res_q;
  assign out_tag    = tag_q;

  // Next-state, counter and capture logic; flush overrides every transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_tag_d = op_tag_q;
    res_d    = res_q;
    tag_d    = tag_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_a_d   = in_a;
            op_b_d   = in_b;
            op_tag_d = in_tag;
            cnt_d    = CNT_INIT;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            res_d   = core_result;
            tag_d   = op_tag_q;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            if (accept) begin
              op_a_d   = in_a;
              op_b_d   = in_b;
              op_tag_d = in_tag;
              cnt_d    = CNT_INIT;
              state_d  = ST_WAIT;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      op_a_q   <= 32'd0;
      op_b_q   <= 32'd0;
      op_tag_q <= '0;
      res_q    <= 32'd0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_tag_q <= op_tag_d;
      res_q    <= res_d;
      tag_q    <= tag_d;
    end
  end

endmodule

// File: tb/tb_mul_issue_unit.sv
// tb/tb_mul_issue_unit.sv - scoreboard testbench for mul_issue_unit
module tb_mul_issue_unit;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_tag, out_tag;

  logic        x_valid, x_out_ready;
  logic        r1_in_ready, r1_out_valid, r1_busy;
  logic [31:0] r1_result;
  logic [4:0]  r1_tag;
  logic        r15_in_ready, r15_out_valid, r15_busy;
  logic [31:0] r15_result;
  logic [4:0]  r15_tag;
  logic        x_flush;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          at;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  mul_issue_unit #(.LATENCY(LAT), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  mul_issue_unit #(.LATENCY(1), .TAG_W(5)) dut_l1 (
    .clk(clk), .reset(reset), .in_valid(x_valid), .in_ready(r1_in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(x_flush),
    .out_valid(r1_out_valid), .out_ready(x_out_ready), .out_result(r1_result),
    .out_tag(r1_tag), .busy(r1_busy)
  );

  mul_issue_unit #(.LATENCY(15), .TAG_W(5)) dut_l15 (
    .clk(clk), .reset(reset), .in_valid(x_valid), .in_ready(r15_in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(x_flush),
    .out_valid(r15_out_valid), .out_ready(x_out_ready), .out_result(r15_result),
    .out_tag(r15_tag), .busy(r15_busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on the DUT", name);
  endtask

  // Advance to one time unit after the next falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] exp_res, input bit expect_out);
    bit ok;
    exp_t e;
    ok = 0;
    in_a = a;
    in_b = b;
    in_tag = tag;
    in_valid = 1'b1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        ok = 1;
        break;
      end
      step();
      #1;
    end
    if (!ok) bound_fail("issue_accept");
    else if (expect_out) begin
      e.res = exp_res;
      e.tag = tag;
      e.at  = cyc + 1 + LAT;
      q.push_back(e);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      #1;
      if (q.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) bound_fail("drain");
  endtask

  // Monitor: pops the expected entry when a result first appears, then checks it stays put.
  initial begin
    bit   seen;
    exp_t cur;
    seen = 0;
    forever begin
      @(negedge clk);
      #3;
      if (out_valid) begin
        if (!seen) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got result 0x%08h tag %0d with nothing expected", out_result, out_tag);
            cur.res = out_result;
            cur.tag = out_tag;
          end else begin
            cur = q.pop_front();
            chk("result", out_result, cur.res);
            chk("tag", 32'(out_tag), 32'(cur.tag));
            chk("latency_cycle", cyc, cur.at);
          end
          seen = 1;
        end else begin
          chk("hold_result", out_result, cur.res);
          chk("hold_tag", 32'(out_tag), 32'(cur.tag));
        end
        if (out_ready) seen = 0;
      end else begin
        seen = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int lat1, lat15, start;
    reset = 1'b1;
    in_valid = 1'b0;
    in_a = 32'd0;
    in_b = 32'd0;
    in_tag = 5'd0;
    flush = 1'b0;
    out_ready = 1'b0;
    x_valid = 1'b0;
    x_out_ready = 1'b1;
    x_flush = 1'b0;
    step();
    step();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Basic op, then the sign-bit and truncation cases.
    out_ready = 1'b1;
    issue(32'd3, 32'd5, 5'd7, 32'h0000000F, 1);
    drain();
    chk("idle_after_op", 32'(busy), 32'd0);
    issue(32'hFFFFFFFE, 32'd3, 5'd1, 32'hFFFFFFFA, 1);
    drain();
    issue(32'h40000000, 32'd4, 5'd2, 32'h00000000, 1);
    drain();

    // Backpressure followed by a back-to-back accept on the handshake edge.
    out_ready = 1'b0;
    issue(32'h00012345, 32'h10, 5'd3, 32'h00123450, 1);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (out_valid) begin
        got = 1;
        break;
      end
      step();
    end
    if (!got) bound_fail("backpressure_valid");
    in_a = 32'd7;
    in_b = 32'd9;
    in_tag = 5'd4;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    step();
    out_ready = 1'b1;
    issue(32'd7, 32'd9, 5'd4, 32'd63, 1);
    drain();

    // Flush while the counter is still at 1.
    issue(32'd11, 32'd13, 5'd5, 32'd0, 0);
    #1;
    chk("wait_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_idle", 32'(busy), 32'd0);
    chk("flush_no_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("flush_never_valid", 32'(out_valid), 32'd0);

    // Flush with a pending request in IDLE blocks the accept.
    in_a = 32'd2;
    in_b = 32'd2;
    in_tag = 5'd6;
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_idle_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_idle_no_accept", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) step();

    // Asynchronous reset between clock edges during WAIT.
    issue(32'd100, 32'd100, 5'd8, 32'd0, 0);
    #1;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd0);
    step();
    step();
    reset = 1'b0;
    issue(32'd6, 32'd7, 5'd5, 32'h0000002A, 1);
    drain();

    // LATENCY=1 and LATENCY=15 instances.
    in_a = 32'd2;
    in_b = 32'hFFFFFFFF;
    in_tag = 5'd9;
    x_valid = 1'b1;
    #1;
    chk("l1_in_ready", 32'(r1_in_ready), 32'd1);
    chk("l15_in_ready", 32'(r15_in_ready), 32'd1);
    start = cyc;
    lat1 = -1;
    lat15 = -1;
    step();
    x_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      #1;
      if (r1_out_valid && lat1 < 0) begin
        lat1 = cyc - start - 1;
        chk("l1_result", r1_result, 32'hFFFFFFFE);
        chk("l1_tag", 32'(r1_tag), 32'd9);
      end
      if (r15_out_valid && lat15 < 0) begin
        lat15 = cyc - start - 1;
        chk("l15_result", r15_result, 32'hFFFFFFFE);
        chk("l15_tag", 32'(r15_tag), 32'd9);
      end
      step();
    end
    chk("l1_latency", lat1, 32'd1);
    chk("l15_latency", lat15, 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_issue_unit.md
Name: mul_issue_unit

Overview:
Multi-cycle issue/capture wrapper for the combinational 32x32 signed multiplier core (module Multiplier) in the EX stage.
- Accepts an operand pair plus destination tag over a valid/ready handshake.
- Holds the operands stable in registers driving the core for LATENCY cycles, so the core is a declared multicycle path.
- Captures the core's 32-bit result ({P[63], P[30:0]}, passed through unmodified).
- Presents the result downstream over a second valid/ready handshake.
- Supports a pipeline flush.

Parameters:
LATENCY, 2, core settle cycles between operand acceptance and result capture; legal range 1..15.
TAG_W, 5, width of the destination-register tag carried with each operation.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  upstream has an operation.
in_ready  output  1  unit accepts an operation this cycle.
in_a  input  32  multiplier operand, signed.
in_b  input  32  multiplicand operand, signed.
in_tag  input  TAG_W  destination tag.
flush  input  1  synchronous kill of any accepted or held operation.
out_valid  output  1  result available.
out_ready  input  1  downstream consumes result.
out_result  output  32  captured core result.
out_tag  output  TAG_W  tag of the operation in out_result.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, active-high): state=IDLE; op_a, op_b, op_tag, res_q, tag_q, cnt=0; out_valid=0; busy=0. in_ready is forced 0 while reset is high.
- States: IDLE, WAIT, DONE. cnt is 4 bits.
- in_ready = !reset && !flush && (state==IDLE || (state==DONE && out_ready)). Accept = in_valid && in_ready.
- IDLE: on accept, latch in_a/in_b/in_tag into op_a/op_b/op_tag, cnt<=LATENCY-1, go to WAIT.
- WAIT: if cnt==0, res_q<=core result, tag_q<=op_tag, go to DONE; else cnt<=cnt-1. in_valid is ignored.
- DONE: out_valid=1, out_result=res_q, out_tag=tag_q.
  - out_ready && accept: load the new operation and go to WAIT (back-to-back).
  - out_ready && !accept: go to IDLE.
  - !out_ready: hold; out_result and out_tag stay stable.
- Latency: out_valid rises exactly LATENCY clock edges after the accept edge. Peak throughput is one operation per LATENCY+1 cycles.
- op_a/op_b change only on an accept edge; the core inputs are stable for the whole WAIT period.
- flush (sampled at the clock edge, highest priority over everything except reset):
  - next state=IDLE, out_valid=0;
  - no accept in the flush cycle;
  - an operation in WAIT or DONE is discarded;
  - op regs keep their values; res_q and tag_q are not updated.
- flush in the same cycle as out_ready in DONE: the result is considered not delivered. The consumer must qualify with its own flush.
- Reset asserted mid-operation: the operation is lost, all outputs return to reset values immediately (async). Normal operation resumes on the first edge after deassertion.
- Arithmetic: the unit does no arithmetic. The result bit pattern is exactly the core output for (op_a, op_b).
- busy = (state != IDLE), registered-state derived, glitch-free.
- LATENCY outside 1..15: elaboration error via generate-time check.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, WAIT=2'd1, DONE=2'd2), TAG_W default, LATENCY bounds.
- One sub-module: the existing Multiplier core, instantiated once, driven by op_a (multiplier) and op_b (multiplicand).
- FSM, counter and registers live in mul_issue_unit itself; no further split.

Test Plan:
1. LATENCY=2: in_a=3, in_b=5, tag=7, out_ready=1 -> out_valid exactly 2 edges after accept, out_result=0x0000000F, out_tag=7, then IDLE.
2. in_a=0xFFFFFFFE (-2), in_b=3 -> out_result=0xFFFFFFFA; in_a=0x40000000, in_b=4 -> out_result=0x00000000.
3. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_result/out_tag stable, in_ready=0, busy=1. Then out_ready=1 with in_valid=1 -> new op accepted the same edge, next out_valid LATENCY edges later.
4. flush asserted in WAIT (cnt=1) -> next cycle state IDLE, out_valid never rises for that op. flush asserted with in_valid=1 in IDLE -> in_ready=0, nothing accepted.
5. Async reset pulse mid-WAIT (between edges) -> out_valid=0, busy=0, in_ready=0 immediately. After release, op 6*7 -> out_result=0x0000002A.
6. LATENCY=1 and LATENCY=15 builds: 2*-1 -> 0xFFFFFFFE, out_valid 1 and 15 edges after accept respectively.
